// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 multi-master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RESP_OKAY    = 2'd0,
        RESP_SLVERR  = 2'd1,
        RESP_DECERR  = 2'd2,
        RESP_TIMEOUT = 2'd3
    } resp_e;

    // PPROT bit meanings
    localparam logic [2:0] PROT_PRIV   = 3'b001;
    localparam logic [2:0] PROT_NSEC   = 3'b010;
    localparam logic [2:0] PROT_INSTR  = 3'b100;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decoder: top address bits select one of NUM_SLV slaves.
module apb_addr_decoder #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = $clog2(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_dec_err
);

    logic [SEL_W-1:0] w_idx;

    assign w_idx = i_addr[ADDR_W-1 -: SEL_W];
    assign o_idx = w_idx;

    // Indices at or beyond NUM_SLV match no slave and flag a decode error
    always_comb begin
        o_sel     = '0;
        o_dec_err = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_idx == SEL_W'(i)) begin
                o_sel[i]  = 1'b1;
                o_dec_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb4_multi_master.sv
// APB4 bridge: one valid/ready command becomes one SETUP/ACCESS transfer to a decoded
// slave; the result returns on a valid/ready response port with a 2-bit status.
module apb4_multi_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [2:0]                PPROT,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = $clog2(NUM_SLV);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic [2:0]          r_pprot;
    logic [DATA_W-1:0]   r_rdata;
    resp_e               r_resp;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_active;

    logic [ADDR_W-1:0]   w_dec_addr;
    logic [NUM_SLV-1:0]  w_sel;
    logic [SEL_W-1:0]    w_idx;
    logic                w_dec_err;
    logic                w_accept;
    logic                w_done;
    logic                w_tout;
    logic                w_pready;
    logic                w_pslverr;
    logic [DATA_W-1:0]   w_prdata;

    // In IDLE the incoming address is decoded so a bad index can skip straight to RESP;
    // afterwards the decoder sees the latched address for the whole transfer.
    assign w_dec_addr = (r_state == ST_IDLE) ? cmd_addr : r_paddr;

    apb_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_dec (
        .i_addr    (w_dec_addr),
        .o_sel     (w_sel),
        .o_idx     (w_idx),
        .o_dec_err (w_dec_err)
    );

    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_idx == SEL_W'(i)) begin
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
                w_prdata  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_active) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_dec_err ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (TIMEOUT > 0 && r_cnt == CNT_LAST) begin
                    w_tout      = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command, response and wait-counter registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_rdata  <= '0;
            r_resp   <= RESP_OKAY;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_accept) begin
                r_paddr  <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_wdata;
                r_pstrb  <= cmd_write ? cmd_strb : '0;
                r_pprot  <= cmd_prot;
                r_rdata  <= '0;
                r_resp   <= w_dec_err ? RESP_DECERR : RESP_OKAY;
                r_cnt    <= '0;
            end else if (w_done) begin
                r_resp <= w_pslverr ? RESP_SLVERR : RESP_OKAY;
                if (!r_pwrite) begin
                    r_rdata <= w_prdata;
                end
            end else if (w_tout) begin
                r_resp <= RESP_TIMEOUT;
            end else if (r_state == ST_ACCESS && TIMEOUT > 0) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && r_active;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign PSEL      = (r_state == ST_SETUP || r_state == ST_ACCESS) ? w_sel : '0;
    assign PENABLE   = (r_state == ST_ACCESS);
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;

endmodule

// File: tb/tb_apb4_multi_master.sv
// Self-checking bench for apb4_multi_master: directed table, random traffic against a
// transfer-level reference model, decode error, timeout and reset-abort sequences.
module tb_apb4_multi_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [NS-1:0] PSEL;
    logic          PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0] PREADY, PSLVERR;

    // second instance: three slaves, no timeout
    logic          d3_cmd_valid, d3_cmd_ready, d3_rsp_valid, d3_rsp_ready;
    logic [AW-1:0] d3_cmd_addr;
    logic [DW-1:0] d3_rsp_rdata;
    logic [1:0]    d3_rsp_resp;
    logic [2:0]    d3_PSEL;
    logic          d3_PENABLE, d3_PWRITE;
    logic [AW-1:0] d3_PADDR;
    logic [DW-1:0] d3_PWDATA;
    logic [3:0]    d3_PSTRB;
    logic [2:0]    d3_PPROT;
    logic [3*DW-1:0] d3_PRDATA;
    logic [2:0]    d3_PREADY;
    int            d3_acc;
    int            d3_wait;

    always #5 PCLK = ~PCLK;

    apb4_multi_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb4_multi_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3), .TIMEOUT(0)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_write(1'b0),
        .cmd_addr(d3_cmd_addr), .cmd_wdata(32'h0), .cmd_strb(4'h0), .cmd_prot(3'h0),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata),
        .rsp_resp(d3_rsp_resp),
        .PSEL(d3_PSEL), .PENABLE(d3_PENABLE), .PADDR(d3_PADDR), .PWRITE(d3_PWRITE),
        .PWDATA(d3_PWDATA), .PSTRB(d3_PSTRB), .PPROT(d3_PPROT), .PRDATA(d3_PRDATA),
        .PREADY(d3_PREADY), .PSLVERR(3'b000)
    );

    // Behavioural slaves: the addressed slave becomes ready after cfg_wait ACCESS
    // cycles; all other slaves shout ready/error/garbage which must be ignored.
    int          cfg_idx;
    int          cfg_wait;
    bit          cfg_err_wait, cfg_err_done;
    logic [31:0] cfg_rdata;
    int          acc_cnt;

    always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
    always @(posedge PCLK) d3_acc  <= d3_PENABLE ? d3_acc + 1 : 0;

    always_comb begin
        PREADY  = '1;
        PSLVERR = '1;
        for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = ~cfg_rdata ^ i;
        PREADY[cfg_idx]         = (acc_cnt >= cfg_wait);
        PSLVERR[cfg_idx]        = (acc_cnt >= cfg_wait) ? cfg_err_done : cfg_err_wait;
        PRDATA[cfg_idx*DW +: DW] = cfg_rdata;
    end

    assign d3_PREADY = {3{d3_acc >= d3_wait}};
    assign d3_PRDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          wait_n;
        bit          err_wait;
        bit          err_done;
        logic [31:0] rdata;
        int          delay;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          en;
    } exp_t;

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                                logic [2:0] p, int wn, bit ew, bit ed, logic [31:0] rd,
                                int dl, logic [1:0] er, logic [31:0] erd);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p; v.wait_n = wn;
        v.err_wait = ew; v.err_done = ed; v.rdata = rd; v.delay = dl;
        v.exp_resp = er; v.exp_rdata = erd;
        return v;
    endfunction

    // Transfer-level model: decode, then either the slave answers within the
    // timeout window or the bridge gives up after TMO access cycles.
    function automatic exp_t model(vec_t v, int nslv, int tmo);
        exp_t e;
        int   idx = int'(v.addr >> 30);
        int   ready_cycle = v.wait_n + 1;
        if (idx >= nslv) begin
            e.resp = 2'd2; e.rdata = 0; e.en = 0;
        end else if (tmo > 0 && ready_cycle > tmo) begin
            e.resp = 2'd3; e.rdata = 0; e.en = tmo;
        end else begin
            e.resp = v.err_done ? 2'd1 : 2'd0;
            e.rdata = v.write ? 32'h0 : v.rdata;
            e.en = ready_cycle;
        end
        return e;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        exp_t        e;
        int          n, c, sel_cyc, en_cyc, bad;
        logic [3:0]  exp_sel;
        logic [3:0]  exp_strb;
        e = model(v, NS, TMO);
        exp_sel  = 4'b0001 << v.addr[31:30];
        exp_strb = v.write ? v.strb : 4'h0;
        cfg_idx = int'(v.addr[31:30]); cfg_wait = v.wait_n; cfg_err_wait = v.err_wait;
        cfg_err_done = v.err_done; cfg_rdata = v.rdata;
        @(negedge PCLK);
        rsp_ready = (v.delay == 0);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
        chk({tag, "_accept"}, 64'(n < 20), 64'(1));
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        c = 1; sel_cyc = 0; en_cyc = 0; bad = 0;
        while (!rsp_valid && c < 60) begin
            if (PSEL != 0) begin
                sel_cyc++;
                if (PSEL !== exp_sel || PADDR !== v.addr || PWRITE !== v.write ||
                    PWDATA !== v.wdata || PSTRB !== exp_strb || PPROT !== v.prot) bad++;
            end
            if (PENABLE) en_cyc++;
            if (cmd_ready) bad++;
            @(negedge PCLK); c++;
        end
        chk({tag, "_pins"}, 64'(bad), 64'(0));
        chk({tag, "_psel_cyc"}, 64'(sel_cyc), 64'(e.en + 1));
        chk({tag, "_pen_cyc"}, 64'(en_cyc), 64'(e.en));
        chk({tag, "_rsp_lat"}, 64'(c), 64'(2 + e.en));
        chk({tag, "_resp"}, 64'(rsp_resp), 64'(v.exp_resp));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        bad = 0;
        for (int k = 0; k < v.delay; k++) begin
            @(negedge PCLK); c++;
            if (!rsp_valid || rsp_resp !== v.exp_resp || rsp_rdata !== v.exp_rdata ||
                cmd_ready || PSEL != 0 || PENABLE) bad++;
        end
        if (v.delay > 0) chk({tag, "_hold"}, 64'(bad), 64'(0));
        rsp_ready = 1'b1;
        @(negedge PCLK); c++;
        chk({tag, "_done"}, {62'(0), rsp_valid, cmd_ready}, 64'b01);
        chk({tag, "_turn"}, 64'(c), 64'(3 + e.en + v.delay));
    endtask

    vec_t tbl[10];
    vec_t rv;
    exp_t re;
    int   nn, en3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_strb = 0; cmd_prot = 0; rsp_ready = 1;
        cfg_idx = 0; cfg_wait = 0; cfg_err_wait = 0; cfg_err_done = 0; cfg_rdata = 0;
        d3_cmd_valid = 0; d3_cmd_addr = 0; d3_rsp_ready = 0; d3_wait = 0;
        #22;
        chk("reset_ctrl", {60'(0), cmd_ready, rsp_valid, PENABLE, PWRITE}, 64'h0);
        chk("reset_psel", 64'(PSEL), 64'h0);
        chk("reset_data", {PADDR, PWDATA}, 64'h0);
        chk("reset_rsp", {26'(0), rsp_rdata, rsp_resp, PSTRB, PPROT, 1'b0}, 64'h0);
        @(negedge PCLK); PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        tbl[0] = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 0, 32'hFFFF_0000, 0, 2'd0, 32'h0);
        tbl[1] = mk(0, 32'h8000_0004, 32'hCAFE_0001, 4'hF, 3'b010, 3, 0, 0, 32'h1234_5678, 0, 2'd0, 32'h1234_5678);
        tbl[2] = mk(1, 32'h4000_0008, 32'h0BAD_F00D, 4'h3, 3'b001, 0, 0, 1, 32'h5555_AAAA, 0, 2'd1, 32'h0);
        tbl[3] = mk(0, 32'h4000_000C, 32'h0, 4'hF, 3'b100, 2, 1, 0, 32'hA1B2_C3D4, 0, 2'd0, 32'hA1B2_C3D4);
        tbl[4] = mk(0, 32'hC000_0000, 32'h0, 4'h0, 3'b000, 99, 0, 0, 32'h7777_7777, 0, 2'd3, 32'h0);
        tbl[5] = mk(0, 32'hC000_0040, 32'h0, 4'h0, 3'b011, 15, 0, 0, 32'h0F0F_0F0F, 0, 2'd0, 32'h0F0F_0F0F);
        tbl[6] = mk(1, 32'h4000_0000, 32'h1111_2222, 4'h8, 3'b000, 16, 0, 0, 32'h0, 0, 2'd3, 32'h0);
        tbl[7] = mk(1, 32'h8000_0100, 32'h9876_5432, 4'hC, 3'b110, 1, 0, 0, 32'h0, 5, 2'd0, 32'h0);
        tbl[8] = mk(0, 32'h0000_0020, 32'h0, 4'h0, 3'b000, 0, 0, 1, 32'hBEEF_0001, 0, 2'd1, 32'hBEEF_0001);
        tbl[9] = mk(0, 32'h8000_0200, 32'h0, 4'h0, 3'b101, 1, 1, 1, 32'h2468_ACE0, 3, 2'd1, 32'h2468_ACE0);
        for (int i = 0; i < 10; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 30; i++) begin
            rv.write = 1'($urandom_range(0, 1));
            rv.addr = $urandom();
            rv.wdata = $urandom();
            rv.strb = 4'($urandom_range(0, 15));
            rv.prot = 3'($urandom_range(0, 7));
            rv.wait_n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
            rv.err_wait = 1'($urandom_range(0, 1));
            rv.err_done = ($urandom_range(0, 3) == 0);
            rv.rdata = $urandom();
            rv.delay = int'($urandom_range(0, 2));
            re = model(rv, NS, TMO);
            rv.exp_resp = re.resp;
            rv.exp_rdata = re.rdata;
            run_vec($sformatf("rnd%0d", i), rv);
        end

        // decode error on a three-slave bridge: no select pulse at all
        @(negedge PCLK);
        d3_cmd_valid = 1'b1; d3_cmd_addr = 32'hC000_0000; d3_rsp_ready = 1'b0;
        chk("dec_cmd_ready", 64'(d3_cmd_ready), 64'(1));
        @(posedge PCLK); @(negedge PCLK);
        d3_cmd_valid = 1'b0;
        chk("dec_rsp", {d3_rsp_valid, d3_rsp_resp, d3_rsp_rdata}, {1'b1, 2'd2, 32'h0});
        chk("dec_psel", {d3_PSEL, d3_PENABLE}, 64'h0);
        @(negedge PCLK);
        chk("dec_hold", {d3_rsp_valid, d3_rsp_resp, d3_PSEL, d3_cmd_ready}, {1'b1, 2'd2, 3'b000, 1'b0});
        d3_rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("dec_done", {d3_rsp_valid, d3_cmd_ready}, 64'b01);

        // TIMEOUT=0: a very slow slave still completes
        d3_wait = 20; d3_cmd_valid = 1'b1; d3_cmd_addr = 32'h8000_0000;
        @(posedge PCLK); @(negedge PCLK);
        d3_cmd_valid = 1'b0; nn = 0; en3 = 0;
        while (!d3_rsp_valid && nn < 60) begin
            if (d3_PENABLE) en3++;
            if (d3_PENABLE && d3_PSEL !== 3'b100) en3 += 1000;
            @(negedge PCLK); nn++;
        end
        chk("not_pen_cyc", 64'(en3), 64'(21));
        chk("not_rsp", {d3_rsp_resp, d3_rsp_rdata}, {2'd0, 32'h3333_3333});
        @(negedge PCLK);

        // reset pulse during ACCESS: everything drops at once and no response follows
        cfg_idx = 1; cfg_wait = 99; cfg_err_wait = 0; cfg_err_done = 0; cfg_rdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0044; cmd_wdata = 32'h5A5A_5A5A;
        cmd_strb = 4'hF; cmd_prot = 3'b001;
        @(posedge PCLK); @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_pre_access", {PENABLE, PSEL}, {1'b1, 4'b0010});
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_async_ctrl", {PENABLE, PSEL, cmd_ready, rsp_valid}, 64'h0);
        chk("rst_async_data", {PADDR, PWDATA}, 64'h0);
        @(negedge PCLK); PRESETn = 1'b1;
        nn = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL != 0 || PENABLE) nn++;
        end
        chk("rst_no_rsp", 64'(nn), 64'(0));
        chk("rst_idle", 64'(cmd_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
